timer_writer: RTL

//  Host-side writer for the toaster countdown timer's load interface (write/Time/DC -> write_ack).

---
 rtl/timer_writer_pkg.sv | 13 +
 rtl/timer_writer_if.sv | 12 +
 rtl/timer_writer_sat_updown.sv | 26 ++
 rtl/timer_writer.sv | 115 +++++++++++
 4 files changed

// File: rtl/timer_writer_pkg.sv
// Shared widths, limits and FSM encoding for the toaster timer host-side writer.
package toaster_pkg;
    localparam int TIME_W = 10;
    localparam int DC_W   = 8;
    localparam int DC_MAX = 200;

    typedef enum logic [1:0] {TW_IDLE, TW_REQ, TW_GAP, TW_ERR} tw_state_t;

    // Bits needed to hold the values 0..n-1.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/timer_writer_if.sv
// Load interface between the writer (master) and the countdown timer (slave).
interface timer_writer_if;
    import toaster_pkg::*;

    logic              write;
    logic [TIME_W-1:0] Time;
    logic [DC_W-1:0]   DC;
    logic              write_ack;

    modport master (output write, Time, DC, input write_ack);
    modport slave  (input write, Time, DC, output write_ack);
endinterface

// File: rtl/timer_writer_sat_updown.sv
// Saturating up/down register driven by one-cycle inc/dec pulses.
module sat_updown #(
    parameter int WIDTH = 10,
    parameter int MAX   = 599,
    parameter int STEP  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] value
);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] HI_V   = WIDTH'(MAX - STEP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (inc && !dec) begin
            value <= (value > HI_V) ? MAX_V : value + STEP_V;
        end else if (dec && !inc) begin
            value <= (value < STEP_V) ? '0 : value - STEP_V;
        end
    end
endmodule

// File: rtl/timer_writer.sv
// Host-side writer: edits a set-point, snapshots it with a shade duty code on commit and
// holds a write request to the timer until ack, retrying on timeout.
module timer_writer
    import toaster_pkg::*;
#(
    parameter int MAX_SEC     = 599,
    parameter int STEP_SEC    = 10,
    parameter int DC_BASE     = 60,
    parameter int DC_STEP     = 20,
    parameter int ACK_TIMEOUT = 15,
    parameter int MAX_RETRY   = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inc,
    input  logic              dec,
    input  logic [2:0]        shade,
    input  logic              commit,
    timer_writer_if.master    ld,
    output logic [TIME_W-1:0] set_sec,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int TMO_W = cnt_w(ACK_TIMEOUT);
    localparam int ATT_W = cnt_w(MAX_RETRY + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [ATT_W-1:0] ATT_LAST = ATT_W'(MAX_RETRY);

    tw_state_t         state;
    logic [TMO_W-1:0]  tmo;
    logic [ATT_W-1:0]  attempt;
    logic [TIME_W-1:0] time_q;
    logic [DC_W-1:0]   dc_q;
    logic              write_q;
    logic [9:0]        dc_wide;
    logic [DC_W-1:0]   dc_next;

    sat_updown #(
        .WIDTH (TIME_W),
        .MAX   (MAX_SEC),
        .STEP  (STEP_SEC)
    ) u_setpoint (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (inc),
        .dec     (dec),
        .value   (set_sec)
    );

    // Wide enough that a retuned DC_BASE/DC_STEP overflows into the clamp, not past it.
    assign dc_wide = 10'(DC_BASE) + 10'(shade) * 10'(DC_STEP);
    assign dc_next = (dc_wide > 10'(DC_MAX)) ? DC_W'(DC_MAX) : dc_wide[DC_W-1:0];

    assign ld.write = write_q;
    assign ld.Time  = time_q;
    assign ld.DC    = dc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= TW_IDLE;
            tmo     <= '0;
            attempt <= '0;
            time_q  <= '0;
            dc_q    <= '0;
            write_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                TW_IDLE, TW_ERR: begin
                    if (commit) begin
                        time_q  <= set_sec;
                        dc_q    <= dc_next;
                        attempt <= ATT_W'(1);
                        tmo     <= '0;
                        write_q <= 1'b1;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        state   <= TW_REQ;
                    end
                end
                TW_REQ: begin
                    if (ld.write_ack) begin
                        write_q <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= TW_IDLE;
                    end else if (tmo == TMO_LAST) begin
                        write_q <= 1'b0;
                        tmo     <= '0;
                        if (attempt == ATT_LAST) begin
                            busy  <= 1'b0;
                            err   <= 1'b1;
                            state <= TW_ERR;
                        end else begin
                            attempt <= attempt + ATT_W'(1);
                            state   <= TW_GAP;
                        end
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                TW_GAP: begin
                    tmo     <= '0;
                    write_q <= 1'b1;
                    state   <= TW_REQ;
                end
                default: state <= TW_IDLE;
            endcase
        end
    end
endmodule
